// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Package pipe_pkg: register address width, scoreboard entry layout,
// forwarding-select encoding and stage indices.
package pipe_pkg;

  localparam int RA_W = 5;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic            v;
    logic            wreg;
    logic [RA_W-1:0] wn;
    logic            is_load;
  } sb_entry_t;

  // Forwarding select 0 means "take the register file value".
  localparam int SEL_RF = 0;

  // Stage indices downstream of ID.
  localparam int STG_EX  = 1;
  localparam int STG_MEM = 2;
  localparam int STG_WB  = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage <-> hazard controller signal bundle.
// master: ID stage (drives instruction info, consumes control).
// slave : hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int FWD_STAGES = 3
);
  import pipe_pkg::*;
  localparam int SEL_W = $clog2(FWD_STAGES + 1);

  logic             id_valid;
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             id_wreg;
  logic [RA_W-1:0]  id_wn;
  logic             id_is_load;
  logic             br_taken;
  logic [SEL_W-1:0] fwd_a_sel;
  logic [SEL_W-1:0] fwd_b_sel;
  logic             stall;
  logic             wpc;
  logic             wir;
  logic             flush;
  logic             id_kill;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_wreg, id_wn, id_is_load, br_taken,
    input  fwd_a_sel, fwd_b_sel, stall, wpc, wir, flush, id_kill
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_wreg, id_wn, id_is_load, br_taken,
    output fwd_a_sel, fwd_b_sel, stall, wpc, wir, flush, id_kill
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Priority match of one ID source operand against every scoreboard entry.
// Returns the youngest matching stage (0 = register file) and whether that
// producer is a load. Register 0 never matches.
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int FWD_STAGES = 3,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic             id_valid,
  input  logic             src_used,
  input  logic [RA_W-1:0]  src,
  input  sb_entry_t        sb [1:FWD_STAGES],
  output logic [SEL_W-1:0] sel,
  output logic             is_load
);

  logic [FWD_STAGES:1] hit;

  for (genvar gi = 1; gi <= FWD_STAGES; gi++) begin : g_hit
    assign hit[gi] = id_valid & src_used & sb[gi].v & sb[gi].wreg &
                     (sb[gi].wn != '0) & (sb[gi].wn == src);
  end

  // Scan oldest to youngest so the youngest hit is the last one written.
  always_comb begin
    sel     = SEL_W'(SEL_RF);
    is_load = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (hit[k]) begin
        sel     = SEL_W'(k);
        is_load = sb[k].is_load;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Parametrised pipeline hazard controller: scoreboard of in-flight
// destinations, per-operand forwarding selects, load-use stall and
// branch squash of younger stages.
// Optional build macro PIPE_HAZARD_PERF_EN adds stall/flush cycle counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FWD_STAGES = 3,
  parameter int LOAD_STAGE = 2,
  parameter int BR_STAGE   = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic               clk,
  input  logic               clrn,
  pipe_hazard_ctrl_if.slave  hz
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  localparam logic [SEL_W-1:0] LOAD_SEL = SEL_W'(LOAD_STAGE);

  sb_entry_t        sb_reg  [1:FWD_STAGES];
  sb_entry_t        sb_next [1:FWD_STAGES];
  logic [SEL_W-1:0] a_sel;
  logic [SEL_W-1:0] b_sel;
  logic             a_load;
  logic             b_load;
  logic             stall;
  logic             id_kill;

  pipe_fwd_match #(.FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W)) u_match_a (
    .id_valid (hz.id_valid),
    .src_used (hz.id_rs_used),
    .src      (hz.id_rs),
    .sb       (sb_reg),
    .sel      (a_sel),
    .is_load  (a_load)
  );

  pipe_fwd_match #(.FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W)) u_match_b (
    .id_valid (hz.id_valid),
    .src_used (hz.id_rt_used),
    .src      (hz.id_rt),
    .sb       (sb_reg),
    .sel      (b_sel),
    .is_load  (b_load)
  );

  // A load whose data is not yet forwardable stalls ID; a taken branch
  // overrides because the ID instruction is being squashed anyway.
  assign stall = hz.id_valid & ~hz.br_taken &
                 ((a_load & (a_sel < LOAD_SEL)) | (b_load & (b_sel < LOAD_SEL)));
  assign id_kill = stall | hz.br_taken;

  assign hz.fwd_a_sel = a_sel;
  assign hz.fwd_b_sel = b_sel;
  assign hz.stall     = stall;
  assign hz.wpc       = ~stall;
  assign hz.wir       = ~stall;
  assign hz.flush     = hz.br_taken;
  assign hz.id_kill   = id_kill;

  // Next scoreboard: ID enters stage 1 unless killed; stages younger than
  // the resolving branch become bubbles when it is taken.
  always_comb begin
    if (id_kill) begin
      sb_next[STG_EX] = '0;
    end else begin
      sb_next[STG_EX] = {hz.id_valid, hz.id_wreg, hz.id_wn, hz.id_is_load};
    end
    for (int k = 2; k <= FWD_STAGES; k++) begin
      if (hz.br_taken && ((k - 1) < BR_STAGE)) begin
        sb_next[k] = '0;
      end else begin
        sb_next[k] = sb_reg[k - 1];
      end
    end
  end

  // Scoreboard register; reset clears every entry immediately.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        sb_reg[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        sb_reg[k] <= sb_next[k];
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  // Free-running wrap-around counts of stall and flush cycles.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)       stall_cnt <= stall_cnt + 32'd1;
      if (hz.br_taken) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Two instances (load data
// forwardable from stage 2 and from stage 3) share the same ID stimulus;
// each is checked against a model of the in-flight instruction pipeline.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int FS  = 3;
  localparam int BRS = 2;
  localparam int NI  = 2;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  logic            s_valid, s_rs_used, s_rt_used, s_wreg, s_load, s_br;
  logic [RA_W-1:0] s_rs, s_rt, s_wn;

  logic [1:0]  o_asel  [NI];
  logic [1:0]  o_bsel  [NI];
  logic        o_stall [NI];
  logic        o_wpc   [NI];
  logic        o_wir   [NI];
  logic        o_flush [NI];
  logic        o_kill  [NI];
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] o_scnt  [NI];
  logic [31:0] o_fcnt  [NI];
`endif

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    pipe_hazard_ctrl_if #(.FWD_STAGES(FS)) hif ();
    assign hif.id_valid   = s_valid;
    assign hif.id_rs      = s_rs;
    assign hif.id_rt      = s_rt;
    assign hif.id_rs_used = s_rs_used;
    assign hif.id_rt_used = s_rt_used;
    assign hif.id_wreg    = s_wreg;
    assign hif.id_wn      = s_wn;
    assign hif.id_is_load = s_load;
    assign hif.br_taken   = s_br;
    assign o_asel[gi]  = hif.fwd_a_sel;
    assign o_bsel[gi]  = hif.fwd_b_sel;
    assign o_stall[gi] = hif.stall;
    assign o_wpc[gi]   = hif.wpc;
    assign o_wir[gi]   = hif.wir;
    assign o_flush[gi] = hif.flush;
    assign o_kill[gi]  = hif.id_kill;

    pipe_hazard_ctrl #(
      .FWD_STAGES (FS),
      .LOAD_STAGE (gi + 2),
      .BR_STAGE   (BRS)
    ) dut (
      .clk       (clk),
      .clrn      (clrn),
      .hz        (hif)
`ifdef PIPE_HAZARD_PERF_EN
      ,
      .stall_cnt (o_scnt[gi]),
      .flush_cnt (o_fcnt[gi])
`endif
    );
  end

  // Reference: for each instance, the instruction sitting in each stage.
  sb_entry_t   m_sb   [NI][1:FS];
  logic [31:0] m_scnt [NI];
  logic [31:0] m_fcnt [NI];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest stage holding a register-writing producer of src, else 0.
  function automatic int producer(int i, logic used, logic [RA_W-1:0] src);
    if (!s_valid || !used || src == 0) return 0;
    for (int k = 1; k <= FS; k++)
      if (m_sb[i][k].v && m_sb[i][k].wreg && m_sb[i][k].wn == src) return k;
    return 0;
  endfunction

  // Operand needs a load result that has not reached the forwarding stage.
  function automatic logic exp_stall(int i);
    int a, b, ls;
    logic wait_a, wait_b;
    a  = producer(i, s_rs_used, s_rs);
    b  = producer(i, s_rt_used, s_rt);
    ls = i + 2;
    wait_a = (a != 0) && m_sb[i][a].is_load && (a < ls);
    wait_b = (b != 0) && m_sb[i][b].is_load && (b < ls);
    return !s_br && (wait_a || wait_b);
  endfunction

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      logic es;
      es = exp_stall(i);
      chk($sformatf("L%0d_fwd_a", i + 2), 32'(o_asel[i]),  32'(producer(i, s_rs_used, s_rs)));
      chk($sformatf("L%0d_fwd_b", i + 2), 32'(o_bsel[i]),  32'(producer(i, s_rt_used, s_rt)));
      chk($sformatf("L%0d_stall", i + 2), 32'(o_stall[i]), 32'(es));
      chk($sformatf("L%0d_wpc", i + 2),   32'(o_wpc[i]),   32'(!es));
      chk($sformatf("L%0d_wir", i + 2),   32'(o_wir[i]),   32'(!es));
      chk($sformatf("L%0d_flush", i + 2), 32'(o_flush[i]), 32'(s_br));
      chk($sformatf("L%0d_kill", i + 2),  32'(o_kill[i]),  32'(es || s_br));
`ifdef PIPE_HAZARD_PERF_EN
      chk($sformatf("L%0d_scnt", i + 2), o_scnt[i], m_scnt[i]);
      chk($sformatf("L%0d_fcnt", i + 2), o_fcnt[i], m_fcnt[i]);
`endif
    end
  endtask

  // Every instruction moves one stage older; a taken branch at BRS squashes
  // everything younger than itself, including the instruction in ID.
  task automatic model_clock();
    for (int i = 0; i < NI; i++) begin
      logic es;
      es = exp_stall(i);
      if (es)   m_scnt[i] = m_scnt[i] + 32'd1;
      if (s_br) m_fcnt[i] = m_fcnt[i] + 32'd1;
      for (int k = FS; k >= 2; k--) begin
        if (s_br && (k - 1) < BRS) m_sb[i][k] = '0;
        else                       m_sb[i][k] = m_sb[i][k - 1];
      end
      if (es || s_br) m_sb[i][1] = '0;
      else            m_sb[i][1] = {s_valid, s_wreg, s_wn, s_load};
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int k = 1; k <= FS; k++) m_sb[i][k] = '0;
      m_scnt[i] = '0;
      m_fcnt[i] = '0;
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu, input logic wr,
                        input logic [4:0] wn, input logic ld, input logic br);
    s_valid = v; s_rs = rs; s_rs_used = rsu; s_rt = rt; s_rt_used = rtu;
    s_wreg = wr; s_wn = wn; s_load = ld; s_br = br;
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  initial begin
    model_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    sample();
    chk("rst_wpc", 32'(o_wpc[0]), 32'd1);
    chk("rst_flush", 32'(o_flush[0]), 32'd0);
    $display("reset: wpc=%0d wir=%0d stall=%0d", o_wpc[0], o_wir[0], o_stall[0]);
    clrn = 1'b1;
    advance();
    step();

    // add r5
    set_id(1, 0, 0, 0, 0, 1, 5, 0, 0); step();
    // add r5 reading r5: stage 1 forwards
    set_id(1, 5, 1, 0, 0, 1, 5, 0, 0); sample();
    chk("alu_fwd_a1", 32'(o_asel[0]), 32'd1);
    chk("alu_nostall", 32'(o_stall[0]), 32'd0);
    $display("alu fwd: fwd_a=%0d stall=%0d", o_asel[0], o_stall[0]);
    advance();
    // reader of r5 on rt: youngest of two producers wins
    set_id(1, 0, 0, 5, 1, 0, 0, 0, 0); sample();
    chk("young_fwd_b1", 32'(o_bsel[0]), 32'd1);
    $display("youngest: fwd_b=%0d", o_bsel[0]);
    advance();
    // stage 1 no longer writes: stage 2 wins; this ID is load r8
    set_id(1, 0, 0, 5, 1, 1, 8, 1, 0); sample();
    chk("fwd_b2", 32'(o_bsel[0]), 32'd2);
    $display("stage2: fwd_b=%0d", o_bsel[0]);
    advance();
    // load-use on r8
    set_id(1, 8, 1, 0, 0, 0, 0, 0, 0); sample();
    chk("lu_stall", 32'(o_stall[0]), 32'd1);
    chk("lu_wpc", 32'(o_wpc[0]), 32'd0);
    chk("lu3_stall", 32'(o_stall[1]), 32'd1);
    $display("load-use: stall=%0d/%0d wpc=%0d", o_stall[0], o_stall[1], o_wpc[0]);
    advance();
    sample();
    chk("lu_fwd_a2", 32'(o_asel[0]), 32'd2);
    chk("lu_release", 32'(o_stall[0]), 32'd0);
    chk("lu3_stall2", 32'(o_stall[1]), 32'd1);
    $display("load-use+1: fwd_a=%0d stall=%0d/%0d", o_asel[0], o_stall[0], o_stall[1]);
    advance();
    sample();
    chk("lu3_fwd_a3", 32'(o_asel[1]), 32'd3);
    chk("lu3_release", 32'(o_stall[1]), 32'd0);
    $display("load-use+2: L3 fwd_a=%0d stall=%0d", o_asel[1], o_stall[1]);
    advance();

    // writer of r0, then reader of r0
    set_id(1, 0, 0, 0, 0, 1, 0, 0, 0); step();
    set_id(1, 0, 1, 0, 0, 0, 0, 0, 0); sample();
    chk("r0_fwd_a", 32'(o_asel[0]), 32'd0);
    chk("r0_stall", 32'(o_stall[0]), 32'd0);
    $display("r0: fwd_a=%0d stall=%0d", o_asel[0], o_stall[0]);
    advance();

    // load r9, then hazard coinciding with a taken branch
    set_id(1, 0, 0, 0, 0, 1, 9, 1, 0); step();
    set_id(1, 9, 1, 0, 0, 0, 0, 0, 1); sample();
    chk("br_stall", 32'(o_stall[0]), 32'd0);
    chk("br_flush", 32'(o_flush[0]), 32'd1);
    chk("br_kill", 32'(o_kill[0]), 32'd1);
    chk("br_wpc", 32'(o_wpc[0]), 32'd1);
    $display("branch: stall=%0d flush=%0d kill=%0d", o_stall[0], o_flush[0], o_kill[0]);
    advance();
    set_id(1, 9, 1, 0, 0, 0, 0, 0, 0); sample();
    chk("br_squashed", 32'(o_asel[0]), 32'd0);
    $display("after branch: fwd_a=%0d", o_asel[0]);
    advance();

    // load r10, hazard, then asynchronous reset mid-stall
    set_id(1, 0, 0, 0, 0, 1, 10, 1, 0); step();
    set_id(1, 10, 1, 0, 0, 0, 0, 0, 0); sample();
    chk("pre_rst_stall", 32'(o_stall[0]), 32'd1);
    #2 clrn = 1'b0;
    model_reset();
    #1;
    chk("rst_stall", 32'(o_stall[0]), 32'd0);
    chk("rst_wpc2", 32'(o_wpc[0]), 32'd1);
    chk("rst_fwd_a", 32'(o_asel[0]), 32'd0);
    $display("async reset: stall=%0d wpc=%0d", o_stall[0], o_wpc[0]);
    @(posedge clk);
    @(negedge clk);
    check_all();
    clrn = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();

    // random traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      set_id($urandom_range(0, 3) != 0,
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      step();
    end
    $display("random: 400 cycles done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
